// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and pipeline tag type for the multi-lane MAC.
package mac_pkg;

    typedef struct packed {
        logic vld;
        logic eof;
    } beat_tag_t;

    function automatic int prod_width(input int aw, input int bw);
        return aw + bw;
    endfunction

    function automatic int tree_width(input int aw, input int bw, input int n);
        return aw + bw + $clog2(n);
    endfunction

    // Limits are returned in 64 bits; callers keep the low OUT_WIDTH bits.
    function automatic logic [63:0] sat_max(input int ow);
        return (64'd1 << (ow - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int ow);
        return ~sat_max(ow);
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational signed reduction: one pairwise level per instance, recursing until one operand remains.
module mac_adder_tree #(
    parameter int N_OPS = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + $clog2(N_OPS)
) (
    input  logic [N_OPS*IN_W-1:0] i_ops,
    output logic [OUT_W-1:0]      o_sum
);

    generate
        if (N_OPS == 1) begin : g_leaf
            if (OUT_W > IN_W) begin : g_ext
                assign o_sum = {{(OUT_W-IN_W){i_ops[IN_W-1]}}, i_ops};
            end else begin : g_trunc
                assign o_sum = i_ops[OUT_W-1:0];
            end
        end else begin : g_lvl
            localparam int N_NXT = (N_OPS + 1) / 2;
            logic [N_NXT*(IN_W+1)-1:0] w_nxt;

            for (genvar j = 0; j < N_NXT; j++) begin : g_node
                logic [IN_W-1:0] w_lo;
                assign w_lo = i_ops[2*j*IN_W +: IN_W];
                if (2*j + 1 < N_OPS) begin : g_pair
                    logic [IN_W-1:0] w_hi;
                    assign w_hi = i_ops[(2*j+1)*IN_W +: IN_W];
                    assign w_nxt[j*(IN_W+1) +: IN_W+1] = {w_lo[IN_W-1], w_lo} + {w_hi[IN_W-1], w_hi};
                end else begin : g_pass
                    // Odd operand rides up to the next level unchanged.
                    assign w_nxt[j*(IN_W+1) +: IN_W+1] = {w_lo[IN_W-1], w_lo};
                end
            end

            mac_adder_tree #(
                .N_OPS (N_NXT),
                .IN_W  (IN_W + 1),
                .OUT_W (OUT_W)
            ) u_nxt (
                .i_ops (w_nxt),
                .o_sum (o_sum)
            );
        end
    endgenerate

endmodule

// File: rtl/mac_array.sv
// Multi-lane signed MAC: multiply, adder-tree reduce, then accumulate per frame.
// Three register stages; enable freezes the whole pipeline including outputs.
module mac_array
    import mac_pkg::*;
#(
    parameter int N_LANES   = 4,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 20,
    parameter int SATURATE  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          valid_in,
    input  logic                          eof,
    input  logic [N_LANES*A_WIDTH-1:0]    a,
    input  logic [N_LANES*B_WIDTH-1:0]    b,
    output logic signed [OUT_WIDTH-1:0]   result,
    output logic                          valid_out,
    output logic                          last_out,
    output logic                          ovf
);

    localparam int          PW        = prod_width(A_WIDTH, B_WIDTH);
    localparam logic [63:0] SAT_MAX64 = sat_max(OUT_WIDTH);
    localparam logic [63:0] SAT_MIN64 = sat_min(OUT_WIDTH);

    logic [N_LANES*PW-1:0]  w_prod;
    logic [N_LANES*PW-1:0]  r_prod;
    beat_tag_t              r_tag1;
    logic [OUT_WIDTH:0]     w_tree;
    logic [OUT_WIDTH:0]     r_tree;
    beat_tag_t              r_tag2;

    logic [OUT_WIDTH-1:0]   r_result;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_ovf;
    logic                   r_first;

    logic [OUT_WIDTH:0]     w_base;
    logic [OUT_WIDTH:0]     w_sum;
    logic                   w_ovf;
    logic [OUT_WIDTH-1:0]   w_next;

    generate
        for (genvar i = 0; i < N_LANES; i++) begin : g_lane
            logic [PW-1:0] w_ax;
            logic [PW-1:0] w_bx;
            assign w_ax = {{B_WIDTH{a[i*A_WIDTH+A_WIDTH-1]}}, a[i*A_WIDTH +: A_WIDTH]};
            assign w_bx = {{A_WIDTH{b[i*B_WIDTH+B_WIDTH-1]}}, b[i*B_WIDTH +: B_WIDTH]};
            // Low PW bits of the extended product are the exact signed product.
            assign w_prod[i*PW +: PW] = w_ax * w_bx;
        end
    endgenerate

    mac_adder_tree #(
        .N_OPS (N_LANES),
        .IN_W  (PW),
        .OUT_W (OUT_WIDTH + 1)
    ) u_tree (
        .i_ops (r_prod),
        .o_sum (w_tree)
    );

    assign w_base = r_first ? '0 : {r_result[OUT_WIDTH-1], r_result};
    assign w_sum  = w_base + r_tree;
    assign w_ovf  = w_sum[OUT_WIDTH] ^ w_sum[OUT_WIDTH-1];

    always_comb begin
        w_next = w_sum[OUT_WIDTH-1:0];
        if (SATURATE != 0 && w_ovf) begin
            w_next = w_sum[OUT_WIDTH] ? SAT_MIN64[OUT_WIDTH-1:0] : SAT_MAX64[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod <= '0;
            r_tag1 <= '0;
            r_tree <= '0;
            r_tag2 <= '0;
        end else if (enable) begin
            r_prod <= w_prod;
            r_tag1 <= '{vld: valid_in, eof: valid_in & eof};
            r_tree <= w_tree;
            r_tag2 <= r_tag1;
        end
    end

    // Bubbles leave result, ovf and the frame-start flag untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_ovf    <= 1'b0;
            r_first  <= 1'b1;
        end else if (enable) begin
            r_valid <= r_tag2.vld;
            r_last  <= r_tag2.vld & r_tag2.eof;
            if (r_tag2.vld) begin
                r_result <= w_next;
                r_ovf    <= w_ovf | (r_ovf & ~r_first);
                r_first  <= r_tag2.eof;
            end
        end
    end

    assign result    = r_result;
    assign valid_out = r_valid;
    assign last_out  = r_last;
    assign ovf       = r_ovf;

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised, multi-lane successor to the single-lane pipelined MAC.
- Each accepted beat multiplies N_LANES signed a/b pairs, reduces them in an adder tree and adds the sum into a frame accumulator.
- eof closes the frame and the next beat starts from zero.
- Adds selectable saturation, an overflow flag and a frame-end marker; sits between the sample streamer and the result collector.

Parameters:
- N_LANES, 4, number of parallel multiply lanes (>=1; 1 gives legacy single-lane behaviour).
- A_WIDTH, 8, signed width of each a lane.
- B_WIDTH, 8, signed width of each b lane.
- OUT_WIDTH, 20, signed accumulator/result width; must be >= A_WIDTH+B_WIDTH+$clog2(N_LANES).
- SATURATE, 0, 0 = two's-complement wrap, 1 = clamp to OUT_WIDTH signed range.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global pipeline advance; low freezes all state.
- valid_in  in  1  beat qualifier.
- eof  in  1  last beat of frame; only meaningful with valid_in.
- a  in  N_LANES*A_WIDTH  packed signed lanes, lane 0 in LSBs.
- b  in  N_LANES*B_WIDTH  packed signed lanes, lane 0 in LSBs.
- result  out  OUT_WIDTH  signed running frame sum.
- valid_out  out  1  result updated this cycle (one per accepted beat).
- last_out  out  1  result is the final sum of a frame.
- ovf  out  1  sticky overflow for the current frame.

Behaviour:
- Reset: reset low clears all pipeline registers, the accumulator and the frame-start flag immediately, without waiting for clk.
  - Reset values: result=0, valid_out=0, last_out=0, ovf=0.
  - Deassertion is synchronised externally.
  - Reset mid-frame discards the partial frame; the next accepted beat starts a new frame.
- Accept: a beat is accepted on a rising edge with enable=1 and valid_in=1.
- Stage 1 (edge k): register N_LANES products, each A_WIDTH+B_WIDTH bits signed, plus valid and eof.
- Stage 2 (edge k+1): adder tree sums the products, full precision A_WIDTH+B_WIDTH+$clog2(N_LANES), sign-extended to OUT_WIDTH+1.
- Stage 3 (edge k+2): accumulate.
  - Base is 0 if the frame-start flag is set, else the current result; sum is computed in OUT_WIDTH+1 bits.
  - Overflow means bits [OUT_WIDTH] and [OUT_WIDTH-1] differ.
  - SATURATE=1: clamp to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
  - SATURATE=0: keep the low OUT_WIDTH bits.
- Stage 3 outputs: valid_out=1, last_out=eof of that beat, ovf = overflow OR (ovf if not frame start).
- Latency: a beat accepted at edge k is visible on result/valid_out after edge k+2.
  - Throughput is one beat per clock.
- Frame-start flag: set on reset and after a stage-3 update with eof; cleared by any other stage-3 update.
- Frame boundary: after last_out the next accepted beat restarts at 0 with ovf cleared.
  - Back-to-back frames need no idle cycle.
- No beat in stage 3: valid_out=0 and last_out=0; result and ovf hold the last value.
- Bubbles: eof or a/b with valid_in=0 are ignored and do not end the frame.
- enable=0: every register holds, including valid_out, last_out, result and ovf.
  - Downstream qualifies valid_out with enable.
  - No beat is lost or duplicated across a stall.
- Frame of length 1: valid_out and last_out are asserted together.

Decomposition:
- Package mac_pkg: width helper functions, namely the product width and the tree width using $clog2(N_LANES).
- Package mac_pkg: saturation-limit constants as functions of OUT_WIDTH.
- Sub-module mac_adder_tree: combinational, parametrised in N_LANES and input width.
  - Balanced binary reduction, sign-extending at each level.
  - Odd lane counts pass the leftover operand through.

Test Plan:
- Legacy equivalence (N_LANES=1, OUT_WIDTH=18): a=b=i for i=1..15, eof on i=15 -> final result 1240, 15 valid_out pulses, one last_out coincident with 1240, ovf=0.
- Multi-lane: a lanes {1,2,3,4}, b lanes {5,6,7,8} for 3 beats, eof on the third -> results 70, 140, 210, last_out with 210.
  - Immediate next single-beat frame with the same data and eof -> 70 with last_out.
- Saturation (N_LANES=4, OUT_WIDTH=18): all lanes a=b=-128 for 2 beats, eof on the second.
  - SATURATE=1 -> 65536 then 131071 with ovf=1.
  - SATURATE=0 -> 65536 then -131072 with ovf=1.
  - Following frame ovf=0.
- Stall: enable=0 for 5 cycles mid-frame in the multi-lane case -> result, valid_out and last_out frozen during the stall; final 210 and 3 pulses counted with enable unchanged.
- Bubbles and stray eof: valid_in low for 2 cycles between beats, including eof=1 while valid_in=0 -> no extra pulses, frame not ended, final 210.
- Async reset mid-frame: reset low between clock edges after 2 beats -> outputs 0 immediately; after release, one beat {1..4}x{5..8} with eof -> 70.
